// File: rtl/meas_seq.sv
// meas_seq: auto-ranging gated count measurement sequencer (clear, gate, settle, evaluate, re-range).
// Optional continuous mode: define MEAS_SEQ_CONT_EN to add the run input.
module meas_seq #(
  parameter int          GATE_BASE  = 1000,
  parameter int          SETTLE_CYC = 2,
  parameter logic [15:0] HI_TH      = 16'd60000,
  parameter logic [15:0] LO_TH      = 16'd5000,
  parameter int          MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MEAS_SEQ_CONT_EN
  input  logic        run,
`endif
  input  logic [15:0] cnt_val,
  input  logic [1:0]  range,
  output logic        cnt_clr,
  output logic        gate,
  output logic        cnt_over,
  output logic        cnt_low,
  output logic        busy,
  output logic [15:0] result,
  output logic [1:0]  res_range,
  output logic        res_valid,
  output logic        range_err
);
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, EVAL, WAIT_RNG} state_t;
  localparam logic [7:0] MAXR = 8'(MAX_RETRY);
  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] result_q;
  logic [1:0]  res_range_q;
  logic        range_err_q;
  logic        go, again, up, down, err_now;
`ifdef MEAS_SEQ_CONT_EN
  assign go    = start | run;
  assign again = run;
`else
  assign go    = start;
  assign again = 1'b0;
`endif
  assign up      = cnt_val >= HI_TH && range != 2'd3 && retry_q < MAXR;
  assign down    = cnt_val < LO_TH && range != 2'd0 && retry_q < MAXR;
  assign err_now = cnt_val >= HI_TH || cnt_val < LO_TH;
  assign busy    = state_q != IDLE;
  // Accepted values are presented in the EVAL cycle itself, alongside the strobe.
  assign result    = res_valid ? cnt_val : result_q;
  assign res_range = res_valid ? range : res_range_q;
  assign range_err = res_valid ? err_now : range_err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      result_q    <= '0;
      res_range_q <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      if (res_valid) begin
        result_q    <= cnt_val;
        res_range_q <= range;
        range_err_q <= err_now;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    cnt_clr   = 1'b0;
    gate      = 1'b0;
    cnt_over  = 1'b0;
    cnt_low   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = CLEAR;
        retry_d = '0;
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        timer_d = 24'(GATE_BASE) << {range, 1'b0};
        state_d = GATE;
      end
      GATE: begin
        gate    = 1'b1;
        timer_d = timer_q - 24'd1;
        if (timer_q <= 24'd1) begin
          state_d = SETTLE;
          timer_d = 24'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        timer_d = timer_q - 24'd1;
        state_d = timer_q <= 24'd1 ? EVAL : SETTLE;
      end
      EVAL: begin
        cnt_over = up;
        cnt_low  = !up && down;
        if (up || down) begin
          retry_d = retry_q + 8'd1;
          timer_d = 24'd2;
          state_d = WAIT_RNG;
        end else begin
          res_valid = 1'b1;
          retry_d   = '0;
          state_d   = again ? CLEAR : IDLE;
        end
      end
      WAIT_RNG: begin
        timer_d = timer_q - 24'd1;
        state_d = timer_q <= 24'd1 ? CLEAR : WAIT_RNG;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
